// File: rtl/wgt_pkg.sv
// Shared types for the ping/pong weight-bank loader: FSM states, bank index, length width helper.
package wgt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BANK,
        LOAD,
        COMMIT
    } state_t;

    typedef logic bank_t;

    // Tile length needs one bit more than the address so a full-depth tile is representable.
    function automatic int tile_len_w(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/wgt_bank_ctrl.sv
// Ping/pong ownership tracking: per-bank full flags and lengths, write/read bank pointers.
import wgt_pkg::*;

module wgt_bank_ctrl #(
    parameter int ADDR_WIDTH = 7,
    localparam int TLW = tile_len_w(ADDR_WIDTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           commit,
    input  logic [TLW-1:0] commit_len,
    input  logic           rd_release,
    output logic           wr_bank,
    output logic           wr_full,
    output logic           rd_avail,
    output logic           rd_bank_sel,
    output logic [TLW-1:0] rd_tile_len
);

    logic [1:0]     full;
    logic [TLW-1:0] len [2];
    bank_t          wr_ptr;
    bank_t          rd_ptr;
    logic           release_ok;

    assign release_ok = rd_release && full[rd_ptr];

    // A commit and an accepted release never hit the same bank: the writer only
    // loads an empty bank, and a release needs the read bank to be full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= '0;
            len[0] <= '0;
            len[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (commit && wr_ptr == bank_t'(b)) begin
                    full[b] <= 1'b1;
                    len[b]  <= commit_len;
                end else if (release_ok && rd_ptr == bank_t'(b)) begin
                    full[b] <= 1'b0;
                end
            end
            if (commit)     wr_ptr <= ~wr_ptr;
            if (release_ok) rd_ptr <= ~rd_ptr;
        end
    end

    assign wr_bank     = wr_ptr;
    assign wr_full     = full[wr_ptr];
    assign rd_avail    = full[rd_ptr];
    assign rd_bank_sel = rd_ptr;
    assign rd_tile_len = len[rd_ptr];

endmodule

// File: rtl/wgt_bank_loader.sv
// Weight SRAM write-side loader: streams one tile of rows into the free ping/pong bank.
// Optional abort input is enabled by defining WGT_LOADER_ABORT_EN.
import wgt_pkg::*;

module wgt_bank_loader #(
    parameter int TN         = 128,
    parameter int ADDR_WIDTH = 7,
    localparam int TLW = tile_len_w(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef WGT_LOADER_ABORT_EN
    input  logic                  abort,
`endif
    input  logic                  start,
    input  logic [TLW-1:0]        tile_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [TN*8-1:0]       s_data,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [TN*8-1:0]       wdata,
    output logic                  bank_sel_wr,
    output logic                  rd_avail,
    output logic                  rd_bank_sel,
    output logic [TLW-1:0]        rd_tile_len,
    input  logic                  rd_release,
    output logic                  busy,
    output logic                  tile_done,
    output logic                  len_err
);

    localparam logic [TLW-1:0] MAX_LEN = TLW'(1) << ADDR_WIDTH;

    state_t         state;
    logic [TLW-1:0] cnt;
    logic [TLW-1:0] len_q;
    logic           wr_bank;
    logic           wr_full;
    logic           beat;
    logic           commit;
    logic           abort_req;

`ifdef WGT_LOADER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign s_ready = (state == LOAD);
    assign beat    = s_valid && s_ready;
    assign commit  = (state == COMMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            len_q       <= '0;
            we          <= 1'b0;
            waddr       <= '0;
            wdata       <= '0;
            bank_sel_wr <= 1'b0;
            busy        <= 1'b0;
            tile_done   <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            we        <= 1'b0;
            tile_done <= 1'b0;
            len_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (tile_len == '0 || tile_len > MAX_LEN) begin
                            len_err <= 1'b1;
                        end else begin
                            len_q <= tile_len;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= WAIT_BANK;
                        end
                    end
                end
                WAIT_BANK: begin
                    if (abort_req) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!wr_full) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort_req) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (beat) begin
                        we          <= 1'b1;
                        waddr       <= cnt[ADDR_WIDTH-1:0];
                        wdata       <= s_data;
                        bank_sel_wr <= wr_bank;
                        cnt         <= cnt + 1'b1;
                        // tile_done is raised here so it is high during the COMMIT cycle itself
                        if (cnt == len_q - 1'b1) begin
                            tile_done <= 1'b1;
                            state     <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    wgt_bank_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .commit     (commit),
        .commit_len (len_q),
        .rd_release (rd_release),
        .wr_bank    (wr_bank),
        .wr_full    (wr_full),
        .rd_avail   (rd_avail),
        .rd_bank_sel(rd_bank_sel),
        .rd_tile_len(rd_tile_len)
    );

endmodule

// File: tb/tb_wgt_bank_loader.sv
// Directed/randomized bench for wgt_bank_loader against a tile-queue reference model.
module tb_wgt_bank_loader;

    localparam int TN = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
`ifdef WGT_LOADER_ABORT_EN
    logic          abort = 1'b0;
`endif
    logic          start = 1'b0;
    logic [AW:0]   tile_len = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [TN*8-1:0] s_data = '0;
    logic          we;
    logic [AW-1:0] waddr;
    logic [TN*8-1:0] wdata;
    logic          bank_sel_wr;
    logic          rd_avail;
    logic          rd_bank_sel;
    logic [AW:0]   rd_tile_len;
    logic          rd_release = 1'b0;
    logic          busy;
    logic          tile_done;
    logic          len_err;

    wgt_bank_loader #(.TN(TN), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef WGT_LOADER_ABORT_EN
        .abort(abort),
`endif
        .start(start), .tile_len(tile_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .we(we), .waddr(waddr), .wdata(wdata), .bank_sel_wr(bank_sel_wr),
        .rd_avail(rd_avail), .rd_bank_sel(rd_bank_sel), .rd_tile_len(rd_tile_len),
        .rd_release(rd_release), .busy(busy), .tile_done(tile_done), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          bank;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        int bank;
        int len;
    } tile_t;

    wr_t   got_q[$];
    wr_t   exp_q[$];
    tile_t tiles[$];
    int    n_commit, n_release, done_exp, cur_bank, cur_beats;
    int    last_len[2];
    int    done_cnt = 0;
    int    lerr_cnt = 0;
    int    checks = 0;
    int    errors = 0;

    // Capture SRAM writes and pulses on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (we) got_q.push_back({bank_sel_wr, waddr, wdata});
        if (tile_done) done_cnt++;
        if (len_err) lerr_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rd(input string tag);
        int sel;
        sel = n_release % 2;
        chk({tag, ".rd_avail"}, rd_avail, tiles.size() > 0);
        chk({tag, ".rd_bank_sel"}, rd_bank_sel, sel);
        chk({tag, ".rd_tile_len"}, rd_tile_len, last_len[sel]);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, ".n_writes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, ".write"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic start_tile(input int len);
        start    = 1'b1;
        tile_len = (AW+1)'(len);
        step();
        start     = 1'b0;
        cur_bank  = n_commit % 2;
        cur_beats = 0;
    endtask

    // Offer rows until nb of them have been accepted; fixed selects the 0x11, 0x22, ... pattern.
    task automatic feed(input int nb, input int pct, input bit fixed);
        int guard;
        logic [7:0] b;
        guard = 0;
        while (cur_beats < nb && guard < 300) begin
            s_valid = ($urandom_range(99) < pct);
            b = 8'((cur_beats + 1) * 17);
            s_data = fixed ? {4{b}} : $urandom;
            if (s_valid && s_ready) begin
                exp_q.push_back({1'(cur_bank), AW'(cur_beats), s_data});
                cur_beats++;
            end
            step();
            guard++;
        end
        s_valid = 1'b0;
        chk("beats_accepted", cur_beats, nb);
    endtask

    // Called in the COMMIT cycle; optionally releases the read bank in that same cycle.
    task automatic finish_tile(input int len, input bit rel);
        chk("tile_done_commit", tile_done, 1);
        chk("busy_commit", busy, 1);
        rd_release = rel;
        step();
        rd_release = 1'b0;
        if (rel && tiles.size() > 0) begin
            void'(tiles.pop_front());
            n_release++;
        end
        tiles.push_back('{cur_bank, len});
        last_len[cur_bank] = len;
        n_commit++;
        done_exp++;
        chk("tile_done_pulse", tile_done, 0);
        chk("busy_idle", busy, 0);
        chk("tile_done_count", done_cnt, done_exp);
        check_writes("tile");
        check_rd("commit");
    endtask

    task automatic release_bank();
        rd_release = 1'b1;
        step();
        rd_release = 1'b0;
        if (tiles.size() > 0) begin
            void'(tiles.pop_front());
            n_release++;
        end
        check_rd("release");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".s_ready"}, s_ready, 0);
        chk({tag, ".we"}, we, 0);
        chk({tag, ".waddr"}, waddr, 0);
        chk({tag, ".wdata"}, wdata, 0);
        chk({tag, ".bank_sel_wr"}, bank_sel_wr, 0);
        chk({tag, ".rd_avail"}, rd_avail, 0);
        chk({tag, ".rd_bank_sel"}, rd_bank_sel, 0);
        chk({tag, ".rd_tile_len"}, rd_tile_len, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".tile_done"}, tile_done, 0);
        chk({tag, ".len_err"}, len_err, 0);
    endtask

    task automatic model_reset();
        tiles.delete();
        got_q.delete();
        exp_q.delete();
        n_commit = 0;
        n_release = 0;
        last_len[0] = 0;
        last_len[1] = 0;
    endtask

    initial begin
        model_reset();
        done_exp = 0;
        #3;
        check_reset_outputs("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        // Illegal lengths: 0 and one past the SRAM depth.
        start_tile(0);
        chk("len_err0", len_err, 1);
        chk("len_err0.busy", busy, 0);
        step();
        chk("len_err0.pulse", len_err, 0);
        start_tile(9);
        chk("len_err9", len_err, 1);
        chk("len_err9.busy", busy, 0);
        step();
        chk("len_err.count", lerr_cnt, 2);
        chk("len_err.no_we", got_q.size(), 0);

        // Back-to-back 4-row tile into bank 0.
        start_tile(4);
        feed(4, 100, 1'b1);
        finish_tile(4, 1'b0);
        release_bank();

        // Two tiles fill both banks; a third waits for a release.
        start_tile(8);
        feed(8, 50, 1'b0);
        finish_tile(8, 1'b0);
        start_tile(2);
        feed(2, 60, 1'b0);
        finish_tile(2, 1'b0);
        start_tile(3);
        for (int i = 0; i < 4; i++) begin
            chk("stall.s_ready", s_ready, 0);
            chk("stall.busy", busy, 1);
            step();
        end
        release_bank();
        feed(3, 70, 1'b0);
        finish_tile(3, 1'b0);

        // Commit of one bank in the same cycle as the release of the other.
        release_bank();
        start_tile(5);
        feed(5, 80, 1'b0);
        finish_tile(5, 1'b1);
        release_bank();
        release_bank();

        // Reset in the middle of a tile.
        start_tile(8);
        feed(3, 100, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        step();
        rst_n = 1'b1;
        step();
        start_tile(1);
        feed(1, 100, 1'b0);
        finish_tile(1, 1'b0);

`ifdef WGT_LOADER_ABORT_EN
        start_tile(8);
        feed(3, 100, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort.busy", busy, 0);
        chk("abort.s_ready", s_ready, 0);
        chk("abort.we", we, 0);
        step();
        chk("abort.no_done", done_cnt, done_exp);
        check_writes("abort");
        check_rd("abort");
        start_tile(2);
        feed(2, 100, 1'b0);
        finish_tile(2, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wgt_bank_loader.md
# wgt_bank_loader

Write-side controller for the double-buffered (ping/pong) weight SRAM. Accepts a valid/ready stream of TN-wide INT8 weight rows from the host/DMA path, drives the SRAM host write port (we/waddr/wdata/bank_sel_wr) one tile at a time, and tracks per-bank full/empty ownership. The array-side sequencer reads the bank this block publishes and hands it back with a release pulse.

## Interface
- TN, 128, weight vector width in INT8 elements
- ADDR_WIDTH, 7, SRAM address width; tile depth max 2^ADDR_WIDTH
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; begin loading one tile of tile_len rows
- tile_len  in  ADDR_WIDTH+1  rows in tile, legal 1..2^ADDR_WIDTH, sampled on accepted start
- s_valid  in  1  input row valid
- s_ready  out  1  loader accepts row
- s_data  in  TN*8  input row
- we  out  1  SRAM write enable
- waddr  out  ADDR_WIDTH  SRAM write address
- wdata  out  TN*8  SRAM write data
- bank_sel_wr  out  1  SRAM write bank
- rd_avail  out  1  bank rd_bank_sel holds a complete tile
- rd_bank_sel  out  1  bank the array must read (drives bank_sel_rd)
- rd_tile_len  out  ADDR_WIDTH+1  row count of the published bank
- rd_release  in  1  pulse; array finished with published bank
- busy  out  1  state != IDLE
- tile_done  out  1  one-cycle pulse, tile committed
- len_err  out  1  one-cycle pulse, start rejected for illegal tile_len

## Operation
- State: full[1:0], len0/len1, wr_bank, rd_bank, row counter cnt (ADDR_WIDTH+1 bits), FSM IDLE/WAIT_BANK/LOAD/COMMIT.
- IDLE: start with tile_len==0 or >2^ADDR_WIDTH -> len_err, stay IDLE. Legal start -> latch tile_len, cnt=0, go WAIT_BANK. start outside IDLE ignored.
- WAIT_BANK: if full[wr_bank]==0 -> LOAD, else stall (s_ready=0).
- LOAD: s_ready=1. Each s_valid&&s_ready beat: register we=1, waddr=cnt[ADDR_WIDTH-1:0], wdata=s_data, bank_sel_wr=wr_bank; cnt++. Beat with cnt==tile_len-1 -> COMMIT. No beat -> we=0, waddr/wdata hold.
- COMMIT (one cycle): full[wr_bank]=1, len[wr_bank]=latched len, wr_bank toggles, tile_done=1, -> IDLE.
- Read side: rd_avail=full[rd_bank], rd_bank_sel=rd_bank, rd_tile_len=len[rd_bank]. rd_release while rd_avail -> full[rd_bank]=0, rd_bank toggles. rd_release while !rd_avail ignored.
- Set (COMMIT) and clear (release) in same cycle always target different banks; both take effect.
- Tiles are consumed strictly in commit order; at most two committed tiles outstanding.

## Timing
- Reset values: s_ready=0, we=0, waddr=0, wdata=0, bank_sel_wr=0, rd_avail=0, rd_bank_sel=0, rd_tile_len=0, busy=0, tile_done=0, len_err=0; full=0, wr_bank=rd_bank=0.
- All outputs registered except s_ready, rd_avail, rd_bank_sel, rd_tile_len (decoded from registered state).
- Beat accepted cycle N -> we high cycle N+1; SRAM write completes edge ending N+1.
- Last beat cycle N -> COMMIT N+1 (tile_done high N+1) -> rd_avail high N+2 if rd_bank==that bank; last SRAM write already landed.
- Throughput: one row/cycle in LOAD; per-tile overhead start->LOAD 2 cycles, COMMIT 1 cycle.
- rd_release cycle N -> rd_avail reflects next bank cycle N+1; freed bank usable by WAIT_BANK cycle N+1.
- Reset mid-LOAD: partial tile discarded, both banks empty, we deasserted asynchronously.

## Configuration
- WGT_LOADER_ABORT_EN defined: extra input port abort (1 bit). abort in WAIT_BANK/LOAD -> next cycle IDLE, we=0, s_ready=0, cnt=0, full/len/wr_bank unchanged, no tile_done; abort in IDLE/COMMIT ignored (COMMIT completes).
- Undefined: no abort port; a started tile can only end by completing or rst_n.

## Structure
- Shared package wgt_pkg: FSM state enum (IDLE, WAIT_BANK, LOAD, COMMIT), TILE_LEN_W = ADDR_WIDTH+1 helper, bank index type.
- One sub-module wgt_bank_ctrl: full[1:0], len regs, wr/rd pointers, commit/release logic, rd_* outputs. Top holds FSM, counter and write-port registers.

## Test plan
- TN=4, ADDR_WIDTH=3: start tile_len=4, rows 0x11..0x44 back-to-back -> we on 4 consecutive cycles waddr 0..3 bank 0, tile_done once, rd_avail=1 rd_bank_sel=0 rd_tile_len=4.
- Two tiles (len 8, len 2) with no release -> both banks full; third start holds in WAIT_BANK, s_ready=0; rd_release -> rd_bank_sel=1 rd_tile_len=2, third tile loads to bank 0.
- start tile_len=0 and tile_len=9 -> len_err pulses, busy stays 0, no we.
- s_valid toggled 1/0 randomly on len=8 tile -> exactly 8 writes, addresses 0..7 in order, wdata matches accepted rows.
- COMMIT of bank 1 same cycle as rd_release of bank 0 -> full=2'b10, rd_bank_sel=1, rd_avail=1.
- rst_n low after 3 of 8 beats -> all outputs reset values; fresh len=1 tile writes bank 0 addr 0. With WGT_LOADER_ABORT_EN, abort after 3 beats -> IDLE, no tile_done, full unchanged.
